// File: rtl/led_blink_top.sv
// CSR-controlled LED blinker.
// CONTROL (0x0) holds ENABLE and BLINK_RATE; STATUS (0x4) reports the LED
// state and a running toggle count. The LED half-period is
// BLINK_RATE*CLK_DIV cycles, counted from the most recent CONTROL write.
module led_blink_top #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_write,
  output logic [31:0] csr_rdata,
  output logic        led_out
);

  localparam logic [31:0] ADDR_CTRL = 32'h0000_0000;
  localparam logic [31:0] ADDR_STAT = 32'h0000_0004;

  logic             ctrl_en;
  logic [3:0]       ctrl_rate;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic [7:0]       toggle_cnt;

  logic             ctrl_wr;
  logic             blinking;
  logic [CNT_W-1:0] half_m1;
  logic             wrap;

  // Only the low five write-data bits land in a register.
  logic unused_wdata;
  assign unused_wdata = ^csr_wdata[31:5];

  assign ctrl_wr  = csr_write && (csr_addr == ADDR_CTRL);
  assign blinking = ctrl_en && (ctrl_rate != 4'd0);
  // Last count value of a half-period; only meaningful while blinking.
  assign half_m1  = CNT_W'(ctrl_rate) * CNT_W'(CLK_DIV) - CNT_W'(1);
  assign wrap     = (cnt == half_m1);

  // CONTROL register: low five bits of the write data, rest discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en   <= 1'b0;
      ctrl_rate <= 4'd0;
    end else if (ctrl_wr) begin
      ctrl_en   <= csr_wdata[0];
      ctrl_rate <= csr_wdata[4:1];
    end
  end

  // Blink engine. A CONTROL write restarts the half-period from zero and
  // takes priority over a wrap at the same edge, so a rate change never
  // produces a toggle on the write edge itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      phase      <= 1'b0;
      toggle_cnt <= 8'd0;
    end else if (ctrl_wr) begin
      cnt <= '0;
      if (!csr_wdata[0]) phase <= 1'b0;
    end else if (!ctrl_en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (blinking) begin
      if (wrap) begin
        cnt        <= '0;
        phase      <= ~phase;
        toggle_cnt <= toggle_cnt + 8'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // LED is a function of registered state only, so CSR input activity
  // cannot glitch the pin.
  always_comb begin
    led_out = ctrl_en & (phase | (ctrl_rate == 4'd0));
  end

  // Zero-latency read mux, decoded by exact address match.
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_CTRL: csr_rdata = {27'h0, ctrl_rate, ctrl_en};
      ADDR_STAT: csr_rdata = {16'h0, toggle_cnt, 7'h0, led_out};
      default:   csr_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_led_blink_top.sv
// Bench for led_blink_top. The reference model tracks only the last CONTROL
// write (cycle, phase and toggle count at that moment) and derives the
// current LED phase and toggle count from elapsed cycles by division.
module tb_led_blink_top;
  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_write;
  logic [31:0] csr_rdata;
  logic        led_out;

  led_blink_top #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_write (csr_write),
    .csr_rdata (csr_rdata),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state, captured at the last CONTROL write.
  bit m_en;
  int m_rate;
  int m_anchor;
  bit m_aph;
  int m_atc;

  function automatic int m_toggles(int t);
    if (m_en && m_rate != 0) return (t - m_anchor) / (m_rate * CLK_DIV);
    return 0;
  endfunction

  function automatic bit m_phase(int t);
    if (!m_en) return 1'b0;
    return m_aph ^ bit'(m_toggles(t) % 2);
  endfunction

  function automatic int m_tc(int t);
    return (m_atc + m_toggles(t)) % 256;
  endfunction

  function automatic bit m_led(int t);
    return m_en && (m_phase(t) || m_rate == 0);
  endfunction

  task automatic model_reset();
    m_en = 0; m_rate = 0; m_anchor = cyc; m_aph = 0; m_atc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    bit ph;
    int tc;
    ph = m_phase(cyc);
    tc = m_tc(cyc);
    csr_addr  = addr;
    csr_wdata = data;
    csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
    if (addr == 32'h0) begin
      m_en     = data[0];
      m_rate   = int'(data[4:1]);
      m_anchor = cyc;
      m_aph    = m_en ? ph : 1'b0;
      m_atc    = tc;
    end
  endtask

  // Compare LED, CONTROL and STATUS against the model; leaves addr at 0x4.
  task automatic check_all();
    logic [7:0] tc8;
    tc8 = 8'(m_tc(cyc));
    chk("led", {31'h0, led_out}, {31'h0, m_led(cyc)});
    csr_addr = 32'h0;
    #1 chk("ctrl", csr_rdata, {27'h0, 4'(m_rate), m_en});
    csr_addr = 32'h4;
    #1 chk("status", csr_rdata, {16'h0, tc8, 7'h0, m_led(cyc)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all();
    end
  endtask

  initial begin
    int e;
    logic [7:0] tc_save;
    logic [31:0] d;

    rst_n = 1'b0; csr_addr = 32'h0; csr_wdata = 32'h0; csr_write = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 1: reset state
    check_all();
    csr_addr = 32'h0;
    #1 chk("rst_ctrl", csr_rdata, 32'h0);

    // 2: rate 2 blinking, H = 8
    do_write(32'h0, 32'h5);
    e = cyc;
    csr_addr = 32'h0;
    #1 chk("ctrl5", csr_rdata, 32'h5);
    for (int i = 0; i < 24; i++) begin
      tick();
      check_all();
      if (cyc == e + 8)  chk("rise8",  {31'h0, led_out}, 32'h1);
      if (cyc == e + 16) chk("fall16", {31'h0, led_out}, 32'h0);
      if (cyc == e + 24) begin
        chk("rise24", {31'h0, led_out}, 32'h1);
        chk("st24", csr_rdata, 32'h0000_0301);
      end
    end

    // 3: rate change mid-blink, H = 4, no toggle at the write edge
    run(3);
    do_write(32'h0, 32'h3);
    check_all();
    chk("no_toggle_at_wr", {31'h0, led_out}, 32'h1);
    run(20);

    // 4: steady on, then off
    do_write(32'h0, 32'h1);
    check_all();
    for (int i = 0; i < 50; i++) begin
      tick();
      check_all();
      chk("steady", {31'h0, led_out}, 32'h1);
    end
    csr_addr = 32'h4;
    #1 tc_save = csr_rdata[15:8];
    do_write(32'h0, 32'h0);
    check_all();
    chk("off", {31'h0, led_out}, 32'h0);
    chk("tc_kept", {24'h0, csr_rdata[15:8]}, {24'h0, tc_save});

    // 5: reserved bits, ignored writes, unmapped reads
    do_write(32'h0, 32'hFFFF_FFFF);
    csr_addr = 32'h0;
    #1 chk("ctrl1f", csr_rdata, 32'h1F);
    do_write(32'h8, 32'h0000_0002);
    do_write(32'h4, 32'hFFFF_FFFF);
    csr_addr = 32'h0;
    #1 chk("ctrl_keep", csr_rdata, 32'h1F);
    csr_addr = 32'h8;
    #1 chk("rd8", csr_rdata, 32'h0);
    run(130);

    // Randomized CONTROL writes, stray writes and idle gaps
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          d = $urandom;
          if ($urandom_range(0, 1) == 1) d[4:3] = 2'b00;
          do_write(32'h0, d);
          check_all();
        end
        2: begin
          do_write(($urandom_range(0, 1) == 1) ? 32'h4 : 32'h10 + 32'($urandom_range(0, 7)), $urandom);
          check_all();
        end
        default: ;
      endcase
      run($urandom_range(1, 40));
    end

    // 6: asynchronous reset between edges
    do_write(32'h0, 32'h3);
    run(6);
    csr_addr = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_led", {31'h0, led_out}, 32'h0);
    chk("async_ctrl", csr_rdata, 32'h0);
    csr_addr = 32'h4;
    #1 chk("async_stat", csr_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    do_write(32'h0, 32'h7);
    check_all();
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Cycle-budget watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
